// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller: owns NZCV, evaluates the Execute condition,
// gates write/redirect controls into the M/W pipeline and keeps debug counters.
module cond_exec_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       ALUFlags,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic             UndefE,
    output logic [3:0]       Flags,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic             RegWriteW,
    output logic             PCSrcW,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    logic flag_n, flag_z, flag_c, flag_v, ge;
    logic cond_term;
    logic live;
    logic commit;
    logic squash;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];
    assign ge     = (flag_n == flag_v);

    // Condition decode against the registered flags only (no same-cycle bypass).
    always_comb begin
        cond_term = 1'b0;
        case (CondE)
            COND_EQ: cond_term = flag_z;
            COND_NE: cond_term = ~flag_z;
            COND_CS: cond_term = flag_c;
            COND_CC: cond_term = ~flag_c;
            COND_MI: cond_term = flag_n;
            COND_PL: cond_term = ~flag_n;
            COND_VS: cond_term = flag_v;
            COND_VC: cond_term = ~flag_v;
            COND_HI: cond_term = ~flag_z & flag_c;
            COND_LS: cond_term = flag_z | ~flag_c;
            COND_GE: cond_term = ge;
            COND_LT: cond_term = ~ge;
            COND_GT: cond_term = ~flag_z & ge;
            COND_LE: cond_term = flag_z | ~ge;
            COND_AL: cond_term = 1'b1;
            COND_NV: cond_term = 1'b0;
            default: cond_term = 1'b0;
        endcase
    end

    // Flush dominates stall: a flushed instruction never commits or counts.
    assign live         = ValidE & ~FlushE;
    assign CondExE      = live & cond_term;
    assign BranchTakenE = PCSrcE & CondExE;
    assign UndefE       = live & (CondE == COND_NV);
    assign commit       = CondExE & ~StallE;
    assign squash       = live & ~StallE & ~cond_term;

    // NZ and CV halves load independently on a committed instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= 4'b0000;
        end else if (commit) begin
            if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // M and W never stall; a stalled or squashed Execute slot enters M as a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
            RegWriteW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            RegWriteM <= RegWriteE & commit;
            MemWriteM <= MemWriteE & commit;
            PCSrcM    <= PCSrcE & commit;
            RegWriteW <= RegWriteM;
            PCSrcW    <= PCSrcM;
        end
    end

    // Saturating debug counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ExecCount   <= '0;
            SquashCount <= '0;
        end else begin
            if (commit && (ExecCount != {CNT_W{1'b1}}))
                ExecCount <= ExecCount + CNT_W'(1);
            if (squash && (SquashCount != {CNT_W{1'b1}}))
                SquashCount <= SquashCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed self-checking bench for cond_exec_ctrl (instantiated with 4-bit counters).
module tb_cond_exec_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             ValidE, StallE, FlushE;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       ALUFlags;
    logic             RegWriteE, MemWriteE, PCSrcE;
    logic             CondExE, BranchTakenE, UndefE;
    logic [3:0]       Flags;
    logic             RegWriteM, MemWriteM, PCSrcM, RegWriteW, PCSrcW;
    logic [CNT_W-1:0] ExecCount, SquashCount;

    int errors = 0;
    int checks = 0;

    cond_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE), .UndefE(UndefE),
        .Flags(Flags),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM),
        .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidE = 0; StallE = 0; FlushE = 0; CondE = 4'hE; FlagWriteE = 2'b00;
        ALUFlags = 4'h0; RegWriteE = 0; MemWriteE = 0; PCSrcE = 0;
    endtask

    initial begin
        idle();
        reset_n = 0;
        #2;
        chk("rst_flags", 16'(Flags), 16'h0);
        chk("rst_exec", 16'(ExecCount), 16'h0);
        chk("rst_rwm", 16'(RegWriteM), 16'h0);
        #1 reset_n = 1;

        // CMP-like op then EQ-conditioned register write
        ValidE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        #1 chk("cmp_condex", 16'(CondExE), 16'h1);
        tick();
        chk("cmp_flags", 16'(Flags), 16'h4);
        chk("cmp_exec", 16'(ExecCount), 16'h1);
        CondE = 4'h0; FlagWriteE = 2'b00; ALUFlags = 4'h0; RegWriteE = 1;
        #1 chk("eq_condex", 16'(CondExE), 16'h1);
        tick();
        chk("eq_rwm", 16'(RegWriteM), 16'h1);
        chk("eq_exec", 16'(ExecCount), 16'h2);
        idle();
        tick();
        chk("eq_rwm_clr", 16'(RegWriteM), 16'h0);
        chk("eq_rww", 16'(RegWriteW), 16'h1);
        tick();
        chk("eq_rww_clr", 16'(RegWriteW), 16'h0);

        // Flags cleared, EQ fails: no branch, no store, one squash
        ValidE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'h0;
        tick();
        chk("clr_flags", 16'(Flags), 16'h0);
        CondE = 4'h0; FlagWriteE = 2'b00; MemWriteE = 1; PCSrcE = 1;
        #1;
        chk("eqf_condex", 16'(CondExE), 16'h0);
        chk("eqf_btaken", 16'(BranchTakenE), 16'h0);
        tick();
        chk("eqf_mwm", 16'(MemWriteM), 16'h0);
        chk("eqf_pcm", 16'(PCSrcM), 16'h0);
        chk("eqf_squash", 16'(SquashCount), 16'h1);
        chk("eqf_exec", 16'(ExecCount), 16'h3);
        CondE = 4'hE;
        #1 chk("al_btaken", 16'(BranchTakenE), 16'h1);
        tick();
        chk("al_mwm", 16'(MemWriteM), 16'h1);
        chk("al_pcm", 16'(PCSrcM), 16'h1);
        idle();
        tick();
        chk("al_pcw", 16'(PCSrcW), 16'h1);
        chk("al_pcm_clr", 16'(PCSrcM), 16'h0);
        chk("al_exec", 16'(ExecCount), 16'h4);

        // Signed comparisons with N=1, V=0; then CV-only flag write
        ValidE = 1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'b1000;
        tick();
        chk("nv_flags", 16'(Flags), 16'h8);
        FlagWriteE = 2'b00;
        CondE = 4'hB; #1 chk("lt_condex", 16'(CondExE), 16'h1);
        CondE = 4'hA; #1 chk("ge_condex", 16'(CondExE), 16'h0);
        CondE = 4'hC; #1 chk("gt_condex", 16'(CondExE), 16'h0);
        CondE = 4'hD; #1 chk("le_condex", 16'(CondExE), 16'h1);
        CondE = 4'hE; FlagWriteE = 2'b01; ALUFlags = 4'b0011;
        tick();
        chk("cv_flags", 16'(Flags), 16'hB);
        FlagWriteE = 2'b00;
        CondE = 4'h8; #1 chk("hi_condex", 16'(CondExE), 16'h1);
        CondE = 4'h9; #1 chk("ls_condex", 16'(CondExE), 16'h0);
        chk("cv_exec", 16'(ExecCount), 16'h6);

        // Two stalled cycles then one commit
        CondE = 4'hE; RegWriteE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0101; StallE = 1;
        tick();
        chk("st1_flags", 16'(Flags), 16'hB);
        chk("st1_rwm", 16'(RegWriteM), 16'h0);
        tick();
        chk("st2_rwm", 16'(RegWriteM), 16'h0);
        chk("st2_exec", 16'(ExecCount), 16'h6);
        StallE = 0;
        tick();
        chk("st_commit_flags", 16'(Flags), 16'h5);
        chk("st_commit_rwm", 16'(RegWriteM), 16'h1);
        chk("st_commit_exec", 16'(ExecCount), 16'h7);

        // Stall and flush together: flush wins, nothing happens
        StallE = 1; FlushE = 1; ALUFlags = 4'hF;
        #1 chk("sf_condex", 16'(CondExE), 16'h0);
        tick();
        chk("sf_flags", 16'(Flags), 16'h5);
        chk("sf_rwm", 16'(RegWriteM), 16'h0);
        chk("sf_exec", 16'(ExecCount), 16'h7);
        chk("sf_squash", 16'(SquashCount), 16'h1);

        // Asynchronous reset mid-run
        StallE = 0; FlushE = 0; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'hF; RegWriteE = 1;
        tick();
        chk("pre_rst_flags", 16'(Flags), 16'hF);
        chk("pre_rst_rwm", 16'(RegWriteM), 16'h1);
        idle();
        #1 reset_n = 0;
        #1;
        chk("arst_flags", 16'(Flags), 16'h0);
        chk("arst_rwm", 16'(RegWriteM), 16'h0);
        chk("arst_rww", 16'(RegWriteW), 16'h0);
        chk("arst_exec", 16'(ExecCount), 16'h0);
        chk("arst_squash", 16'(SquashCount), 16'h0);
        #1 reset_n = 1;
        tick();
        chk("post_rst_rww", 16'(RegWriteW), 16'h0);
        chk("post_rst_flags", 16'(Flags), 16'h0);

        // Saturation of the 4-bit executed counter
        ValidE = 1; CondE = 4'hE;
        repeat (14) tick();
        chk("sat_14", 16'(ExecCount), 16'hE);
        repeat (6) tick();
        chk("sat_hold", 16'(ExecCount), 16'hF);

        // Condition 1111: undefined and squashed
        CondE = 4'hF;
        #1;
        chk("nv_undef", 16'(UndefE), 16'h1);
        chk("nv_condex", 16'(CondExE), 16'h0);
        FlushE = 1;
        #1 chk("nv_undef_flush", 16'(UndefE), 16'h0);
        FlushE = 0;
        tick();
        chk("nv_squash", 16'(SquashCount), 16'h1);
        chk("nv_exec", 16'(ExecCount), 16'hF);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- Conditional-execution controller for the pipelined ARM core. Owns the architectural NZCV flags register.
- Evaluates the Execute-stage condition field against the stored flags and gates RegWrite, MemWrite and PCSrc.
- Carries the gated controls through the Memory and Writeback pipeline registers.
- Counts executed and squashed instructions for debug.

Parameters:
- CNT_W, 16, width of the saturating executed/squashed counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ValidE  in  1  a real instruction occupies Execute (not a bubble).
- StallE  in  1  hazard unit holds Execute this cycle.
- FlushE  in  1  hazard unit kills the Execute instruction this cycle.
- CondE  in  4  instruction condition field.
- FlagWriteE  in  2  [1] = update NZ, [0] = update CV.
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- RegWriteE  in  1  ungated register-write request.
- MemWriteE  in  1  ungated memory-write request.
- PCSrcE  in  1  ungated PC-redirect request (branch or write to R15).
- CondExE  out  1  Execute instruction passes its condition.
- BranchTakenE  out  1  PCSrcE & CondExE, sent to fetch and the hazard unit.
- UndefE  out  1  CondE == 4'b1111 on a valid, unflushed instruction.
- Flags  out  4  current registered {N,Z,C,V}.
- RegWriteM  out  1  gated register write, Memory stage.
- MemWriteM  out  1  gated memory write, Memory stage.
- PCSrcM  out  1  gated PC source, Memory stage.
- RegWriteW  out  1  gated register write, Writeback stage.
- PCSrcW  out  1  gated PC source, Writeback stage.
- ExecCount  out  CNT_W  instructions that passed their condition.
- SquashCount  out  CNT_W  valid instructions that failed their condition.

Behaviour:
- Reset (reset_n low, asynchronous): Flags = 0000; all M/W registers = 0; both counters = 0. The M/W registers, flags and counters are forced to 0 immediately, independent of clk, and resume normal updates on the first rising edge after reset_n returns high. Reset mid-instruction drops all in-flight gated writes.
- Condition encoding, evaluated combinationally on registered Flags (GE = N==V):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: ~Z&C
  - 1001 LS: Z|~C
  - 1010 GE: GE
  - 1011 LT: ~GE
  - 1100 GT: ~Z&GE
  - 1101 LE: Z|~GE
  - 1110 AL: 1
  - 1111: treated as not executed (CondEx term = 0) and asserts UndefE.
- CondExE = ValidE & ~FlushE & condition term. CondExE, BranchTakenE and UndefE are combinational outputs, with zero-cycle latency.
- Commit = CondExE & ~StallE.
- Flags update on the clock edge only when Commit is true:
  - FlagWriteE[1] loads N,Z from ALUFlags.
  - FlagWriteE[0] loads C,V from ALUFlags.
  - The two halves are independent.
  - An instruction sees flags written by the previous committed instruction; there is no same-cycle bypass.
- M register on each edge:
  - RegWriteM <= RegWriteE & Commit.
  - MemWriteM <= MemWriteE & Commit.
  - PCSrcM <= PCSrcE & Commit.
  - While stalled, a bubble (zeros) enters M.
- W register: RegWriteW <= RegWriteM, PCSrcW <= PCSrcM, every edge. M and W never stall.
- Counters:
  - ExecCount increments on Commit.
  - SquashCount increments on ValidE & ~FlushE & ~StallE & ~condition term; this includes cond 1111.
  - Flushed or stalled cycles count nothing.
  - Both counters saturate at all-ones and never wrap.
- StallE and FlushE together: the flush wins. No commit, no flag write, no count.
- ValidE = 0 (bubble): no flag write, no count, and zeros enter M.

Test Plan:
1. Reset mid-run with Flags=1111, RegWriteM=1, counters nonzero, then pulse reset_n low for half a cycle -> Flags=0000, all M/W outputs 0, counters 0, all asynchronously, before the next edge.
2. CMP-like op with CondE=1110, FlagWriteE=11, ALUFlags=0100, then next cycle CondE=0000 with RegWriteE=1 -> Flags=0100 after edge 1; second op CondExE=1, RegWriteM=1 one cycle later, RegWriteW=1 two cycles later.
3. Flags=0000, CondE=0000, MemWriteE=1, PCSrcE=1 -> CondExE=0, BranchTakenE=0, MemWriteM=0, PCSrcM=0, SquashCount+1.
4. Flags=1000 (N=1,V=0): CondE=1011 -> CondExE=1; CondE=1010 -> 0; CondE=1100 -> 0. Then FlagWriteE=01 with ALUFlags=0011 -> Flags=1011 (NZ held, C and V set to 1).
5. CondE=1110, RegWriteE=1, FlagWriteE=11 with StallE=1 for 2 cycles then 0 -> Flags unchanged and RegWriteM=0 during the stall; one commit; ExecCount+1 (not +3). Same with StallE=1 and FlushE=1 -> no commit and no count.
6. CNT_W=4, drive 20 committing AL instructions -> ExecCount reaches 4'hF and holds. CondE=1111 -> UndefE=1, CondExE=0, SquashCount+1.
